// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP serialiser/deserialiser: FSM state encodings
// and the legal frame-width range.
package ssp_pkg;

    localparam int DATA_W_MIN = 4;
    localparam int DATA_W_MAX = 16;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SYNC  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_END   = 2'd3
    } tx_state_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/ssp_sync2.sv
// Two-flop synchroniser for a single asynchronous input, clears to 0 on reset.
module ssp_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ssp_serdes.sv
// SSP-style serial transmitter/receiver with a pclk-derived SSPCLKOUT.
// Define SSP_LOOPBACK_EN to add a loopback input that feeds RX from the TX side.
module ssp_serdes
    import ssp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              pclk,
    input  logic              pclear_b,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
`ifdef SSP_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e          tx_state_q, tx_state_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               sclk_q, sclk_d;
    logic               fss_q, fss_d;
    logic               txd_q, txd_d;
    logic               oe_b_q, oe_b_d;
    logic               tx_done_q, tx_done_d;
    logic               div_wrap;
    logic               tx_edge;

    rx_state_e          rx_state_q, rx_state_d;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_ovr_q, rx_ovr_d;
    logic               clk_prev_q;
    logic               word_done;
    logic               rx_edge;

    logic               clk_src, fss_src, rxd_src;
    logic               clk_s, fss_s, rxd_s;

    // The divider free-runs; the counter compares with >= so a smaller divide
    // value latched while idle never strands it above the wrap point.
    assign div_wrap = (div_cnt_q >= div_q);
    assign tx_edge  = div_wrap && !sclk_q;

    always_comb begin
        sclk_d    = sclk_q;
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_wrap) begin
            div_cnt_d = '0;
            sclk_d    = ~sclk_q;
        end
    end

    // SYNC drives FSS with the MSB pre-presented; SHIFT then emits all DATA_W
    // bits so a falling-edge receiver sees FSS one period ahead of the data.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        div_d      = div_q;
        fss_d      = fss_q;
        txd_d      = txd_q;
        oe_b_d     = oe_b_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                div_d = clk_div;
                if (tx_valid) begin
                    tx_sh_d    = tx_data;
                    tx_state_d = TX_SYNC;
                end
            end
            TX_SYNC: begin
                if (tx_edge) begin
                    oe_b_d     = 1'b0;
                    fss_d      = 1'b1;
                    txd_d      = tx_sh_q[DATA_W-1];
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_edge) begin
                    fss_d    = 1'b0;
                    txd_d    = tx_sh_q[DATA_W-1];
                    tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == LAST_BIT) begin
                        tx_state_d = TX_END;
                    end
                end
            end
            TX_END: begin
                if (tx_edge) begin
                    oe_b_d     = 1'b1;
                    txd_d      = 1'b0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

`ifdef SSP_LOOPBACK_EN
    assign clk_src = loopback ? sclk_q : SSPCLKIN;
    assign fss_src = loopback ? fss_q  : SSPFSSIN;
    assign rxd_src = loopback ? txd_q  : SSPRXD;
`else
    assign clk_src = SSPCLKIN;
    assign fss_src = SSPFSSIN;
    assign rxd_src = SSPRXD;
`endif

    ssp_sync2 u_sync_clk (.clk_i(pclk), .rst_ni(pclear_b), .d_i(clk_src), .q_o(clk_s));
    ssp_sync2 u_sync_fss (.clk_i(pclk), .rst_ni(pclear_b), .d_i(fss_src), .q_o(fss_s));
    ssp_sync2 u_sync_rxd (.clk_i(pclk), .rst_ni(pclear_b), .d_i(rxd_src), .q_o(rxd_s));

    assign rx_edge = clk_prev_q && !clk_s;

    // A new word wins over the consumer's pop; overrun only when nobody took it.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        word_done  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_edge && fss_s) begin
                    rx_state_d = RX_SHIFT;
                    rx_cnt_d   = '0;
                    rx_sh_d    = '0;
                end
            end
            RX_SHIFT: begin
                if (rx_edge) begin
                    if (fss_s) begin
                        rx_cnt_d = '0;
                        rx_sh_d  = '0;
                    end else begin
                        rx_sh_d  = {rx_sh_q[DATA_W-2:0], rxd_s};
                        rx_cnt_d = rx_cnt_q + 1'b1;
                        if (rx_cnt_q == LAST_BIT) begin
                            word_done  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        if (word_done) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                rx_ovr_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge pclear_b) begin
        if (!pclear_b) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            fss_q      <= 1'b0;
            txd_q      <= 1'b0;
            oe_b_q     <= 1'b1;
            tx_done_q  <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            clk_prev_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= sclk_d;
            fss_q      <= fss_d;
            txd_q      <= txd_d;
            oe_b_q     <= oe_b_d;
            tx_done_q  <= tx_done_d;
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            clk_prev_q <= clk_s;
        end
    end

    assign tx_ready   = (tx_state_q == TX_IDLE);
    assign tx_done    = tx_done_q;
    assign SSPCLKOUT  = sclk_q;
    assign SSPFSSOUT  = fss_q;
    assign SSPTXD     = txd_q;
    assign SSPOE_B    = oe_b_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_ovr_q;

endmodule

// File: doc/ssp_serdes.md
SSP_SERDES -- requirements
Module: ssp_serdes

Interface
REQ-001 SHALL have parameter DATA_W, default 8, serial frame width in bits, legal 4..16.
REQ-002 SHALL have parameter DIV_W, default 8, width of the clock-divider setting.
REQ-003 SHALL have port pclk, input, 1, the single system clock.
REQ-004 SHALL have port pclear_b, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port clk_div, input, DIV_W, SSPCLKOUT half-period in pclk cycles minus 1.
REQ-006 SHALL have port tx_data, input, DATA_W, word to transmit.
REQ-007 SHALL have ports tx_valid (input, 1) and tx_ready (output, 1), the TX word handshake.
REQ-008 SHALL have port tx_done, output, 1, one-pclk pulse when a frame completes.
REQ-009 SHALL have ports SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, output, 1 each: serial clock, frame sync, data, active-low output enable.
REQ-010 SHALL have ports SSPCLKIN, SSPFSSIN, SSPRXD, input, 1 each: serial clock, frame sync, data, all asynchronous to pclk.
REQ-011 SHALL have ports rx_data (output, DATA_W), rx_valid (output, 1) and rx_ready (input, 1), the RX word handshake.
REQ-012 SHALL have port rx_overrun, output, 1, sticky flag for a lost RX word.

Function
REQ-013 Divider: counter runs from 0 to the latched divide value, SSPCLKOUT toggles on the wrap; clk_div=0 gives pclk/2. "TX edge" = cycle in which SSPCLKOUT goes 0->1.
REQ-014 clk_div SHALL be latched only while TX is IDLE; changes mid-frame SHALL NOT affect the current frame.
REQ-015 TX FSM states: IDLE, SYNC, SHIFT, END. tx_ready=1 only in IDLE.
REQ-016 TX transfer: tx_valid&&tx_ready in IDLE latches tx_data and moves to SYNC; tx_ready falls the next cycle.
REQ-017 SYNC: at the next TX edge, SSPOE_B=0 and SSPFSSOUT=1 for exactly one SSPCLKOUT period; SSPTXD=MSB; then SHIFT.
REQ-018 SHIFT: the remaining bits go out MSB-first, one per TX edge, with SSPFSSOUT=0; DATA_W bits total, then END.
REQ-019 END: at the next TX edge, SSPOE_B=1 and SSPTXD=0; tx_done pulses for one pclk; return to IDLE.
REQ-020 Frame latency: tx accept to tx_done = (DATA_W+1) SSPCLKOUT periods plus the wait to the first TX edge.
REQ-021 RX front end: SSPCLKIN, SSPFSSIN and SSPRXD SHALL pass through 2-flop synchronisers; "RX edge" = synchronised SSPCLKIN falling edge.
REQ-022 RX FSM states: IDLE, SHIFT. An RX edge with SSPFSSIN=1 in IDLE moves to SHIFT; the next DATA_W RX edges sample SSPRXD MSB-first.
REQ-023 On the last sample, the word loads into rx_data and rx_valid is set; rx_valid holds until rx_valid&&rx_ready, then clears.
REQ-024 A word completing while rx_valid=1 SHALL overwrite rx_data and set rx_overrun; rx_overrun clears only on reset.
REQ-025 Same-cycle clear and new word: clear and reload together; rx_valid stays 1 and no overrun is flagged.
REQ-026 An SSPFSSIN=1 seen mid-SHIFT SHALL restart the frame: bit count resets and the partial word is discarded.

Reset
REQ-027 pclear_b=0 SHALL asynchronously force: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, tx_ready=1 (released), tx_done=0, rx_data=0, rx_valid=0, rx_overrun=0, both FSMs to IDLE, divider and synchronisers to 0.
REQ-028 Reset mid-frame SHALL abort the frame with no tx_done and no rx_valid.

Configuration
REQ-029 Macro SSP_LOOPBACK_EN defined: extra input loopback (1 bit) is present; when loopback=1, RX uses internal SSPCLKOUT/SSPFSSOUT/SSPTXD in place of the pins, still through the synchronisers, and the pins are ignored.
REQ-030 SSP_LOOPBACK_EN undefined: no loopback port; RX always uses the pins.

Structure
REQ-031 Shared package ssp_pkg SHALL hold the TX/RX state enums and the DATA_W legal-range constants.
REQ-032 Sub-module ssp_sync2 (2-flop synchroniser, reset to 0) SHALL be instantiated once per async input.

Verification
REQ-033 DATA_W=8, clk_div=0, send 0xA5 -> FSSOUT one-period pulse, then TXD 1,0,1,0,0,1,0,1 on successive TX edges, OE_B low throughout, one tx_done.
REQ-034 Loopback with DATA_W=12, clk_div=3, send 0xF0C -> rx_valid with rx_data=0xF0C, rx_overrun=0.
REQ-035 Two RX frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, rx_overrun=1.
REQ-036 Change clk_div 0->5 mid-frame -> current frame keeps pclk/2; next frame uses a 6-pclk half-period.
REQ-037 Assert pclear_b after bit 3 of 0x3C -> immediate reset outputs, no tx_done; new tx_valid accepted afterwards.
REQ-038 SSPFSSIN re-pulse after 4 bits, then a full frame of 0x81 -> single rx_valid with 0x81.
